// File: rtl/dqn_no_mem.sv
// Memory-less DQN inference core: serially loaded fp32 weight banks and a sequential
// forward pass (one fp32 multiplier, one adder) followed by greedy argmax over the Q-values.
module dqn_no_mem #(
  parameter int unsigned DATA_WIDTH                    = 32,
  parameter int unsigned ACTION_WIDTH                  = 2,
  parameter int unsigned LAYER_WIDTH                   = 2,
  parameter int unsigned MEMORY_WIDTH                  = 13,
  parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3,
  parameter logic [31:0] ALPHA                         = 32'h3DCCCCCD,
  parameter logic [31:0] LEARNING_RATE                 = 32'h3B03126F,
  parameter logic [31:0] GAMMA                         = 32'h3F4CCCCD,
  parameter logic [31:0] UPDATE_RATE                   = 32'h3F000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_current_state_0,
  input  logic [DATA_WIDTH-1:0]   i_current_state_1,
  input  logic [DATA_WIDTH-1:0]   i_reward,
  input  logic [ACTION_WIDTH-1:0] i_action,
  input  logic [DATA_WIDTH-1:0]   i_next_state_0,
  input  logic [DATA_WIDTH-1:0]   i_next_state_1,
  input  logic                    i_done,
  input  logic                    i_weight_valid,
  input  logic [LAYER_WIDTH-1:0]  i_weight_layer,
  input  logic [10:0]             i_weight_addr,
  input  logic [DATA_WIDTH-1:0]   i_weight,
  input  logic                    i_update_request,
  output logic [ACTION_WIDTH-1:0] o_action,
  output logic                    o_action_valid
);

  localparam int unsigned NI = NUMBER_OF_INPUT_NODE;
  localparam int unsigned N1 = NUMBER_OF_HIDDEN_NODE_LAYER_1;
  localparam int unsigned N2 = NUMBER_OF_HIDDEN_NODE_LAYER_2;
  localparam int unsigned NO = NUMBER_OF_OUTPUT_NODE;
  localparam int unsigned W1_WORDS = N1 * (NI + 1);
  localparam int unsigned W2_WORDS = N2 * (N1 + 1);
  localparam int unsigned WO_WORDS = NO * (N2 + 1);
  localparam int unsigned A1 = $clog2(W1_WORDS);
  localparam int unsigned A2 = $clog2(W2_WORDS);
  localparam int unsigned AO = $clog2(WO_WORDS);
  localparam int unsigned IX = $clog2(NI);
  localparam int unsigned I1 = $clog2(N1);
  localparam int unsigned I2 = $clog2(N2);
  localparam int unsigned IO = $clog2(NO);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, L1, L2, OUT, ARGMAX, DONE} state_t;

  state_t state, state_next;
  logic [5:0] k, node, fan, nodes;
  logic [10:0] base;
  logic [31:0] acc, w, bias, xin, mul_a, mul_b, prod, sum, act;
  logic hidden, act_phase, last_k, layer_done;
  logic [ACTION_WIDTH-1:0] best;
  logic [31:0] x  [NI];
  logic [31:0] h1 [N1];
  logic [31:0] h2 [N2];
  logic [31:0] q  [NO];
  logic [31:0] w1 [W1_WORDS];
  logic [31:0] w2 [W2_WORDS];
  logic [31:0] wo [WO_WORDS];

  logic unused;
  assign unused = ^{i_reward, i_action, i_next_state_0, i_next_state_1, i_done,
                    i_update_request, LEARNING_RATE, GAMMA, UPDATE_RATE, 32'(MEMORY_WIDTH)};

  // Round-to-nearest-even on a normalised 1.m mantissa; subnormal results flush to signed zero.
  function automatic logic [31:0] fp_pack(input logic s, input int e, input logic [22:0] m,
                                          input logic g, input logic st);
    logic [23:0] r;
    int ee;
    ee = e;
    r = {1'b0, m} + 24'(g & (st | m[0]));
    if (r[23]) ee++;
    if (ee >= 255) return {s, 8'hFF, 23'd0};
    if (ee <= 0) return {s, 31'd0};
    return {s, ee[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, s, g, st;
    logic [7:0] ea, eb;
    logic [22:0] ma, mb, m;
    logic [47:0] p;
    int e;
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    s = sa ^ sb;
    if ((ea == 8'hFF && ma != '0) || (eb == 8'hFF && mb != '0)) return QNAN;
    if (ea == 8'hFF || eb == 8'hFF) return (ea == '0 || eb == '0) ? QNAN : {s, 8'hFF, 23'd0};
    if (ea == '0 || eb == '0) return {s, 31'd0};
    p = {1'b1, ma} * {1'b1, mb};
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; st = |p[22:0]; e++;
    end else begin
      m = p[45:23]; g = p[22]; st = |p[21:0];
    end
    return fp_pack(s, e, m, g, st);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, sx, sy;
    logic [7:0] ea, eb, ex, ey, d;
    logic [22:0] ma, mb, mx, my;
    logic [26:0] xm, ym, ysh;
    logic [27:0] sm;
    int e;
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    if ((ea == 8'hFF && ma != '0) || (eb == 8'hFF && mb != '0)) return QNAN;
    if (ea == 8'hFF && eb == 8'hFF) return (sa != sb) ? QNAN : a;
    if (ea == 8'hFF) return a;
    if (eb == 8'hFF) return b;
    if (ea == '0 && eb == '0) return {sa & sb, 31'd0};
    if (ea == '0) return b;
    if (eb == '0) return a;
    if ({ea, ma} >= {eb, mb}) begin
      sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
    end else begin
      sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
    end
    d   = ex - ey;
    xm  = {1'b1, mx, 3'b000};
    ym  = {1'b1, my, 3'b000};
    ysh = ym >> d;
    if ((ysh << d) != ym) ysh[0] = 1'b1;
    e = int'(ex);
    if (sx == sy) begin
      sm = {1'b0, xm} + {1'b0, ysh};
      if (sm[27]) begin
        sm = {1'b0, sm[27:2], sm[1] | sm[0]};
        e++;
      end
    end else begin
      sm = {1'b0, xm} - {1'b0, ysh};
      if (sm == '0) return '0;
      for (int unsigned i = 0; i < 26; i++) begin
        if (!sm[26]) begin
          sm = sm << 1;
          e--;
        end
      end
    end
    return fp_pack(sx, e, sm[25:3], sm[2], |sm[1:0]);
  endfunction

  // NaN never wins; +0 and -0 compare equal; strict so ties keep the lower index.
  function automatic logic q_better(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF && a[22:0] != '0) return 1'b0;
    if (b[30:23] == 8'hFF && b[22:0] != '0) return 1'b1;
    if (a[30:0] == '0 && b[30:0] == '0) return 1'b0;
    if (a[31] != b[31]) return !a[31];
    return a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
  endfunction

  always_comb begin
    fan    = '0;
    nodes  = '0;
    hidden = 1'b0;
    w      = '0;
    bias   = '0;
    xin    = '0;
    unique case (state)
      L1:      begin fan = 6'(NI); nodes = 6'(N1); hidden = 1'b1; end
      L2:      begin fan = 6'(N1); nodes = 6'(N2); hidden = 1'b1; end
      OUT:     begin fan = 6'(N2); nodes = 6'(NO); end
      default: ;
    endcase
    base = 11'(node) * (11'(fan) + 11'd1);
    unique case (state)
      L1: begin
        w    = w1[A1'(base + 11'(k))];
        bias = w1[A1'(base + 11'(fan))];
        xin  = x[k[IX-1:0]];
      end
      L2: begin
        w    = w2[A2'(base + 11'(k))];
        bias = w2[A2'(base + 11'(fan))];
        xin  = h1[k[I1-1:0]];
      end
      OUT: begin
        w    = wo[AO'(base + 11'(k))];
        bias = wo[AO'(base + 11'(fan))];
        xin  = h2[k[I2-1:0]];
      end
      default: ;
    endcase
    // Hidden nodes spend one extra step reusing the multiplier for the leaky-ReLU slope.
    act_phase  = hidden && (k == fan);
    last_k     = hidden ? act_phase : (k == fan - 6'd1);
    layer_done = last_k && (node == nodes - 6'd1);
    mul_a      = act_phase ? acc : w;
    mul_b      = act_phase ? ALPHA : xin;
    prod       = fp_mul(mul_a, mul_b);
    sum        = fp_add((k == '0) ? bias : acc, prod);
    act        = acc[31] ? prod : acc;

    best = '0;
    for (int unsigned i = 1; i < NO; i++) begin
      if (q_better(q[IO'(i)], q[IO'(best)])) best = ACTION_WIDTH'(i);
    end

    state_next = state;
    unique case (state)
      IDLE:    if (i_valid) state_next = L1;
      L1:      if (layer_done) state_next = L2;
      L2:      if (layer_done) state_next = OUT;
      OUT:     if (layer_done) state_next = ARGMAX;
      ARGMAX:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      node     <= '0;
      acc      <= '0;
      o_action <= '0;
    end else begin
      state <= state_next;
      if (state == ARGMAX) o_action <= best;
      if (hidden || state == OUT) begin
        if (!act_phase) acc <= sum;
        if (last_k) begin
          k    <= '0;
          node <= layer_done ? '0 : node + 6'd1;
        end else begin
          k <= k + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && i_valid) begin
      x[0] <= i_current_state_0;
      x[1] <= i_current_state_1;
    end
    if (state == L1 && act_phase) h1[I1'(node)] <= act;
    if (state == L2 && act_phase) h2[I2'(node)] <= act;
    if (state == OUT && last_k) q[IO'(node)] <= sum;
    if (state == IDLE && i_weight_valid) begin
      case (i_weight_layer)
        LAYER_WIDTH'(1): if (i_weight_addr < 11'(W1_WORDS)) w1[A1'(i_weight_addr)] <= i_weight;
        LAYER_WIDTH'(2): if (i_weight_addr < 11'(W2_WORDS)) w2[A2'(i_weight_addr)] <= i_weight;
        LAYER_WIDTH'(3): if (i_weight_addr < 11'(WO_WORDS)) wo[AO'(i_weight_addr)] <= i_weight;
        default: ;
      endcase
    end
  end

  assign o_action_valid = (state == DONE);

endmodule

// File: tb/tb_dqn_no_mem.sv
// Bench for dqn_no_mem: real-arithmetic reference forward pass, queue of expected actions,
// and a per-cycle monitor on o_action / o_action_valid.
module tb_dqn_no_mem;

  localparam logic [31:0] ALPHA = 32'h3DCCCCCD;
  localparam logic [31:0] NEG1  = 32'hBF800000;
  localparam logic [31:0] POS1  = 32'h3F800000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_done, i_weight_valid, i_update_request;
  logic [31:0] i_current_state_0, i_current_state_1, i_reward, i_next_state_0, i_next_state_1;
  logic [31:0] i_weight;
  logic [1:0]  i_action, i_weight_layer;
  logic [10:0] i_weight_addr;
  logic [1:0]  o_action;
  logic        o_action_valid;

  always #5 clk = ~clk;

  dqn_no_mem dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid),
    .i_current_state_0(i_current_state_0), .i_current_state_1(i_current_state_1),
    .i_reward(i_reward), .i_action(i_action),
    .i_next_state_0(i_next_state_0), .i_next_state_1(i_next_state_1),
    .i_done(i_done), .i_weight_valid(i_weight_valid), .i_weight_layer(i_weight_layer),
    .i_weight_addr(i_weight_addr), .i_weight(i_weight), .i_update_request(i_update_request),
    .o_action(o_action), .o_action_valid(o_action_valid)
  );

  logic [31:0] mw1 [96];
  logic [31:0] mw2 [1056];
  logic [31:0] mwo [99];
  int checks = 0;
  int errors = 0;
  int done_count = 0;
  logic [1:0] exp_q [$];
  logic [1:0] exp_hold = 2'd0;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) d = {f[31], 63'd0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
    else d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [23:0] m;
    int e;
    d = $realtobits(r);
    if (d[62:52] == 11'h7FF) return (d[51:0] != '0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'd0};
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 896;
    m = {1'b0, d[51:29]} + 24'(d[28] & ((|d[27:0]) | d[29]));
    if (m[23]) e++;
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] fmul_m(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fadd_m(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic bit is_nan(input logic [31:0] f);
    return f[30:23] == 8'hFF && f[22:0] != '0;
  endfunction

  function automatic logic [1:0] model_action(input logic [31:0] s0, input logic [31:0] s1);
    logic [31:0] xs [2];
    logic [31:0] h1 [32];
    logic [31:0] h2 [32];
    logic [31:0] q [3];
    logic [31:0] acc;
    int best;
    xs[0] = s0; xs[1] = s1;
    for (int j = 0; j < 32; j++) begin
      acc = mw1[j*3 + 2];
      for (int i = 0; i < 2; i++) acc = fadd_m(acc, fmul_m(mw1[j*3 + i], xs[i]));
      h1[j] = acc[31] ? fmul_m(acc, ALPHA) : acc;
    end
    for (int j = 0; j < 32; j++) begin
      acc = mw2[j*33 + 32];
      for (int i = 0; i < 32; i++) acc = fadd_m(acc, fmul_m(mw2[j*33 + i], h1[i]));
      h2[j] = acc[31] ? fmul_m(acc, ALPHA) : acc;
    end
    for (int j = 0; j < 3; j++) begin
      acc = mwo[j*33 + 32];
      for (int i = 0; i < 32; i++) acc = fadd_m(acc, fmul_m(mwo[j*33 + i], h2[i]));
      q[j] = acc;
    end
    best = 0;
    for (int j = 1; j < 3; j++)
      if (!is_nan(q[j]) && (is_nan(q[best]) || f2r(q[j]) > f2r(q[best]))) best = j;
    return 2'(best);
  endfunction

  always @(negedge clk) begin : monitor
    logic [1:0] e;
    checks++;
    if (o_action_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid action=%0d required=no pulse", o_action);
      end else begin
        e = exp_q.pop_front();
        if (o_action !== e) begin
          errors++;
          $display("FAIL result action=%0d required=%0d", o_action, e);
        end
        exp_hold = e;
      end
      done_count++;
    end else if (o_action !== exp_hold || o_action_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold action=%0d valid=%b required action=%0d valid=0",
               o_action, o_action_valid, exp_hold);
    end
  end

  task automatic wr(input logic [1:0] layer, input int addr, input logic [31:0] val, input bit taken);
    i_weight_valid = 1'b1;
    i_weight_layer = layer;
    i_weight_addr  = 11'(addr);
    i_weight       = val;
    @(posedge clk); #1;
    i_weight_valid = 1'b0;
    if (taken) begin
      case (layer)
        2'd1: mw1[addr] = val;
        2'd2: mw2[addr] = val;
        2'd3: mwo[addr] = val;
        default: ;
      endcase
    end
  endtask

  task automatic start_pass(input logic [31:0] s0, input logic [31:0] s1,
                            input logic [1:0] lit, input string name);
    logic [1:0] m;
    m = model_action(s0, s1);
    checks++;
    if (m !== lit) begin
      errors++;
      $display("FAIL model_%s model=%0d required=%0d", name, m, lit);
    end
    i_current_state_0 = s0;
    i_current_state_1 = s1;
    i_valid = 1'b1;
    exp_q.push_back(m);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [1:0] lit, input string name);
    int target;
    bit got;
    target = done_count + 1;
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (done_count >= target) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout_%s no o_action_valid within 4000 cycles", name);
    end else if (o_action !== lit) begin
      errors++;
      $display("FAIL dut_%s action=%0d required=%0d", name, o_action, lit);
    end
  endtask

  task automatic pass(input logic [31:0] s0, input logic [31:0] s1,
                      input logic [1:0] lit, input string name);
    start_pass(s0, s1, lit, name);
    wait_done(lit, name);
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0; i_done = 1'b0; i_weight_valid = 1'b0; i_update_request = 1'b0;
    i_current_state_0 = '0; i_current_state_1 = '0; i_reward = 32'h3F800000;
    i_next_state_0 = '0; i_next_state_1 = '0; i_action = 2'd1;
    i_weight = '0; i_weight_layer = '0; i_weight_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (o_action !== 2'd0) begin errors++; $display("FAIL reset_action action=%0d required=0", o_action); end
    if (o_action_valid !== 1'b0) begin errors++; $display("FAIL reset_valid valid=%b required=0", o_action_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < 96; a++) wr(2'd1, a, 32'h0, 1'b1);
    for (int a = 0; a < 1056; a++) wr(2'd2, a, 32'h0, 1'b1);
    for (int a = 0; a < 99; a++) wr(2'd3, a, 32'h0, 1'b1);

    pass(32'hBEF283C2, 32'h3B84707D, 2'd0, "all_zero_tie");
    wr(2'd3, 98, 32'h3F800000, 1'b1);
    pass(32'hBEF283C2, 32'h3B84707D, 2'd2, "bias_q2");
    wr(2'd3, 65, 32'h40000000, 1'b1);
    pass(32'hBEF283C2, 32'h3B84707D, 2'd1, "bias_q1");

    wr(2'd3, 98, 32'h0, 1'b1);
    wr(2'd3, 65, 32'h0, 1'b1);
    wr(2'd1, 0, POS1, 1'b1);
    wr(2'd2, 0, POS1, 1'b1);
    wr(2'd3, 33, NEG1, 1'b1);
    pass(NEG1, 32'h0, 2'd1, "leaky_neg");

    wr(2'd0, 98, 32'h41200000, 1'b0);
    wr(2'd3, 99, 32'h41200000, 1'b0);
    wr(2'd1, 96, 32'h41200000, 1'b0);
    pass(POS1, 32'h0, 2'd0, "leaky_pos");

    start_pass(POS1, 32'h0, 2'd0, "busy_write");
    repeat (10) @(posedge clk);
    #1;
    wr(2'd3, 98, 32'h41200000, 1'b0);
    wait_done(2'd0, "busy_write");
    pass(POS1, 32'h0, 2'd0, "busy_write_after");

    start_pass(NEG1, 32'h0, 2'd1, "busy_valid");
    for (int n = 0; n < 3; n++) begin
      repeat (5) @(posedge clk);
      #1;
      i_current_state_0 = POS1;
      i_valid = 1'b1;
      i_update_request = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_update_request = 1'b0;
    end
    wait_done(2'd1, "busy_valid");
    repeat (1400) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained pending=%0d required=0", exp_q.size());
    end

    start_pass(NEG1, 32'h0, 2'd1, "mid_reset");
    repeat (600) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_hold = 2'd0;
    #1;
    checks += 2;
    if (o_action !== 2'd0) begin errors++; $display("FAIL mid_reset_action action=%0d required=0", o_action); end
    if (o_action_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid valid=%b required=0", o_action_valid); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (1500) @(posedge clk);
    #1;
    pass(NEG1, 32'h0, 2'd1, "after_reset");

    wr(2'd3, 32, 32'h7FC00000, 1'b1);
    pass(POS1, 32'h0, 2'd2, "nan_q0");

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
